input_logic: RTL and testbench
==============================

INPUT_LOGIC -- requirements
Module: input_logic

Interface
REQ-001 Parameter NUM_PORTS, default 3, number of output FIFOs fed; legal range 1..4.
REQ-002 Parameter DATA_W, default 8, word width; fixed at 8 by header format.
REQ-003 One clock; reset is asynchronous and active-low: ports clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 data_in  input  DATA_W  word from upstream source, stable while data_in_req=1 and data_in_ack=0.
REQ-007 data_in_req  input  1  source has a valid word on data_in.
REQ-008 data_in_ack  output  1  one-cycle pulse, word on data_in consumed.
REQ-009 fifo_full  input  NUM_PORTS  per-destination FIFO full flags.
REQ-010 fifo_push  output  NUM_PORTS  one-hot push strobe, at most one bit high per cycle.
REQ-011 fifo_data  output  DATA_W  word written with fifo_push.
REQ-012 drop_cnt  output  8  dropped-packet count (present only with macro, REQ-030).

Function
REQ-013 Packet format: header word, dest=data[7:6], len=data[5:0], then len payload words (len 0..63).
REQ-014 FSM states: HDR (await header), FWD (forward payload), DROP (discard payload).
REQ-015 Acceptance: in a cycle with data_in_req=1, data_in_ack=0 and accept condition true, the word is captured at the rising edge.
REQ-016 Accept condition: HDR with legal dest -> !fifo_full[dest]; HDR with illegal dest -> always; FWD -> !fifo_full[latched dest]; DROP -> always.
REQ-017 Cycle after capture: data_in_ack=1 for exactly one cycle; no word sampled in that cycle; peak rate 1 word per 2 cycles.
REQ-018 Forwarded words: fifo_push[dest]=1 and fifo_data=captured word in same cycle as data_in_ack (registered, latency 1).
REQ-019 Header with dest<NUM_PORTS is pushed to FIFO dest; dest and len latched; len>0 -> FWD, len=0 -> stays HDR.
REQ-020 Header with dest>=NUM_PORTS: not pushed, acked; len>0 -> DROP, len=0 -> stays HDR; counts as one dropped packet.
REQ-021 FWD/DROP: 6-bit remaining counter loaded with len, decremented per accepted word; word accepted at count 1 returns FSM to HDR.
REQ-022 fifo_full[dest] high: word stalls, no ack, no push, source holds; resumes the cycle full deasserts.
REQ-023 data_in_req deasserted mid-packet: FSM holds state and counter indefinitely.
REQ-024 fifo_full bits of non-target ports ignored.

Reset
REQ-025 On rst_n=0: FSM=HDR, counter=0, latched dest=0, data_in_ack=0, fifo_push=0, fifo_data=0, drop_cnt=0.
REQ-026 Reset mid-packet abandons the packet; next accepted word after release is parsed as a header.
REQ-027 Reset asserts asynchronously; all registers release on the first clk edge with rst_n=1.

Configuration
REQ-028 Macro INPUT_LOGIC_DROP_CNT_EN controls the drop counter.
REQ-029 Undefined: no drop_cnt port, no counter register; drop behaviour otherwise identical.
REQ-030 Defined: drop_cnt increments by 1 per illegal-dest header at its ack cycle, saturates at 255, never wraps.

Structure
REQ-031 Shared package yas_router_pkg holds header field positions (DEST_MSB=7, DEST_LSB=6, LEN_MSB=5, LEN_LSB=0) and FSM state encodings HDR/FWD/DROP.
REQ-032 Single module; no sub-module (header decode is inline combinational logic).

Verification
REQ-033 Header 0x43 (dest1,len3) + 3 payload words, FIFOs empty -> fifo_push=3'b010 four times, data 0x43,p0,p1,p2, four ack pulses, FSM ends HDR.
REQ-034 Header 0x80 (dest2,len0) -> single push on port 2, FSM stays HDR; next word parsed as header.
REQ-035 Header 0xC2 (dest3, NUM_PORTS=3) + 2 words -> three acks, zero pushes, drop_cnt 0->1 (macro defined).
REQ-036 fifo_full[1]=1 for 5 cycles during 0x42 payload -> no ack/push for those 5 cycles, transfer completes in order after release.
REQ-037 rst_n pulsed low after 1 of 3 payload words -> all outputs 0; following word 0x01 pushed to port 0 as header.
REQ-038 256 illegal headers (0xC0) -> drop_cnt saturates at 255.

Source files
------------

// File: rtl/yas_router_pkg.sv
// rtl/yas_router_pkg.sv - header field positions, FSM encodings and decode helpers
package yas_router_pkg;

  localparam int DEST_MSB = 7;
  localparam int DEST_LSB = 6;
  localparam int LEN_MSB  = 5;
  localparam int LEN_LSB  = 0;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_e;

  function automatic logic [1:0] hdr_dest(input logic [7:0] w);
    return w[DEST_MSB:DEST_LSB];
  endfunction

  function automatic logic [5:0] hdr_len(input logic [7:0] w);
    return w[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/input_logic_if.sv
// rtl/input_logic_if.sv - source-side req/ack and FIFO-side push signals
interface input_logic_if #(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 8
);
  logic [DATA_W-1:0]    data_in;
  logic                 data_in_req;
  logic                 data_in_ack;
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_push;
  logic [DATA_W-1:0]    fifo_data;

  modport master (
    output data_in, data_in_req, fifo_full,
    input  data_in_ack, fifo_push, fifo_data
  );

  modport slave (
    input  data_in, data_in_req, fifo_full,
    output data_in_ack, fifo_push, fifo_data
  );
endinterface

// File: rtl/input_logic.sv
// rtl/input_logic.sv - packet parser steering words to per-port FIFOs
// Optional drop counter enabled by INPUT_LOGIC_DROP_CNT_EN.
module input_logic
  import yas_router_pkg::*;
#(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef INPUT_LOGIC_DROP_CNT_EN
  output logic [7:0]        drop_cnt,
`endif
  input_logic_if.slave      bus
);

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [1:0]           dest_q, dest_d;
  logic                 ack_q, ack_d;
  logic [NUM_PORTS-1:0] push_q, push_d;
  logic [DATA_W-1:0]    data_q, data_d;

  logic [1:0] in_dest;
  logic [5:0] in_len;
  logic [1:0] tgt;
  logic       legal;
  logic       tgt_full;
  logic       ok;
  logic       accept;

  // Target port is the incoming header's dest in HDR, else the latched dest.
  always_comb begin
    in_dest  = hdr_dest(bus.data_in);
    in_len   = hdr_len(bus.data_in);
    legal    = 32'(in_dest) < NUM_PORTS;
    tgt      = (state_q == HDR) ? in_dest : dest_q;
    tgt_full = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (tgt == 2'(i)) tgt_full = bus.fifo_full[i];
    end
    case (state_q)
      HDR:     ok = legal ? !tgt_full : 1'b1;
      FWD:     ok = !tgt_full;
      default: ok = 1'b1;
    endcase
    accept = bus.data_in_req && !ack_q && ok;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dest_d  = dest_q;
    ack_d   = 1'b0;
    push_d  = '0;
    data_d  = data_q;
    if (accept) begin
      ack_d = 1'b1;
      case (state_q)
        HDR: begin
          cnt_d = in_len;
          if (legal) begin
            dest_d = in_dest;
            data_d = bus.data_in;
            for (int i = 0; i < NUM_PORTS; i++) push_d[i] = (in_dest == 2'(i));
            if (in_len != 6'd0) state_d = FWD;
          end else if (in_len != 6'd0) begin
            state_d = DROP;
          end
        end
        FWD: begin
          data_d = bus.data_in;
          for (int i = 0; i < NUM_PORTS; i++) push_d[i] = (dest_q == 2'(i));
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = HDR;
        end
        default: begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = HDR;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR;
      cnt_q   <= '0;
      dest_q  <= '0;
      ack_q   <= 1'b0;
      push_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      ack_q   <= ack_d;
      push_q  <= push_d;
      data_q  <= data_d;
    end
  end

  assign bus.data_in_ack = ack_q;
  assign bus.fifo_push   = push_q;
  assign bus.fifo_data   = data_q;

`ifdef INPUT_LOGIC_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       drop_hdr;

  assign drop_hdr = accept && (state_q == HDR) && !legal;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_hdr && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_input_logic.sv
// tb/tb_input_logic.sv - directed self-checking bench for input_logic
module tb_input_logic;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  input_logic_if #(.NUM_PORTS(3), .DATA_W(8)) bus ();

`ifdef INPUT_LOGIC_DROP_CNT_EN
  logic [7:0] drop_cnt;
  input_logic #(.NUM_PORTS(3), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .drop_cnt(drop_cnt), .bus(bus)
  );
`else
  input_logic #(.NUM_PORTS(3), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word from a negedge, wait for its ack, check the push, then the ack drop.
  task automatic xfer(input logic [7:0] w, input logic [2:0] exp_push, input string tag);
    int n;
    bus.data_in     = w;
    bus.data_in_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.data_in_ack !== 1'b1 && n < 20);
    if (n >= 20) check({tag, "_timeout"}, 32'd0, 32'd1);
    bus.data_in_req = 1'b0;
    check({tag, "_push"}, 32'(bus.fifo_push), 32'(exp_push));
    if (exp_push != 3'b000) check({tag, "_data"}, 32'(bus.fifo_data), 32'(w));
    @(negedge clk);
    check({tag, "_ackpulse"}, 32'(bus.data_in_ack), 32'd0);
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst_n           = 1'b0;
    bus.data_in     = 8'h00;
    bus.data_in_req = 1'b0;
    bus.fifo_full   = 3'b000;
    repeat (3) @(negedge clk);
    check("rst_ack",  32'(bus.data_in_ack), 32'd0);
    check("rst_push", 32'(bus.fifo_push), 32'd0);
    check("rst_data", 32'(bus.fifo_data), 32'd0);
`ifdef INPUT_LOGIC_DROP_CNT_EN
    check("rst_drop", 32'(drop_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Dest 1, len 3 with non-target ports full.
    bus.fifo_full = 3'b101;
    xfer(8'h43, 3'b010, "p43_hdr");
    xfer(8'hA1, 3'b010, "p43_w0");
    xfer(8'hA2, 3'b010, "p43_w1");
    xfer(8'hA3, 3'b010, "p43_w2");
    bus.fifo_full = 3'b000;

    // Zero-length packet, next word must be a header.
    xfer(8'h80, 3'b100, "p80_hdr");
    xfer(8'h41, 3'b010, "p41_hdr");
    xfer(8'h99, 3'b010, "p41_w0");

    // Stall on target full for five cycles.
    xfer(8'h42, 3'b010, "p42_hdr");
    bus.fifo_full   = 3'b010;
    bus.data_in     = 8'h5A;
    bus.data_in_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_ack",  32'(bus.data_in_ack), 32'd0);
      check("stall_push", 32'(bus.fifo_push), 32'd0);
    end
    bus.fifo_full = 3'b000;
    xfer(8'h5A, 3'b010, "p42_w0");
    xfer(8'h5B, 3'b010, "p42_w1");

    // Illegal dest 3: acked, never pushed.
    xfer(8'hC2, 3'b000, "pC2_hdr");
    xfer(8'h11, 3'b000, "pC2_w0");
    xfer(8'h22, 3'b000, "pC2_w1");
`ifdef INPUT_LOGIC_DROP_CNT_EN
    check("drop_one", 32'(drop_cnt), 32'd1);
`endif
    xfer(8'h01, 3'b001, "p01_hdr");
    xfer(8'h77, 3'b001, "p01_w0");

    // Reset in the middle of a packet.
    xfer(8'h43, 3'b010, "rst_hdr");
    xfer(8'hB1, 3'b010, "rst_w0");
    rst_n = 1'b0;
    #1;
    check("mid_rst_ack",  32'(bus.data_in_ack), 32'd0);
    check("mid_rst_push", 32'(bus.fifo_push), 32'd0);
    check("mid_rst_data", 32'(bus.fifo_data), 32'd0);
`ifdef INPUT_LOGIC_DROP_CNT_EN
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(8'h01, 3'b001, "post_rst_hdr");
    xfer(8'h55, 3'b001, "post_rst_w0");

`ifdef INPUT_LOGIC_DROP_CNT_EN
    for (int i = 0; i < 254; i++) xfer(8'hC0, 3'b000, "sat_hdr");
    check("drop_254", 32'(drop_cnt), 32'd254);
    xfer(8'hC0, 3'b000, "sat_hdr");
    check("drop_255", 32'(drop_cnt), 32'd255);
    xfer(8'hC0, 3'b000, "sat_hdr");
    xfer(8'hC0, 3'b000, "sat_hdr");
    check("drop_sat", 32'(drop_cnt), 32'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
